vid_scanout: RTL and testbench

Video scan-out engine for the XERA4 system: the read side of video memory, which the CPU fills through its video port (`Video_Add`/`Video_Out`/`Video_we`). The block generates raster timing, fetches one bitmap byte every 8 pixel clocks from a 1-cycle-latency read port, and serialises it MSB-first into a 1-bit pixel stream with `hsync`/`vsync`/`de`. It never writes video memory.

---
 rtl/vid_scanout.sv | 153 +++++++++++++++
 tb/tb_vid_scanout.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vid_scanout.sv
// vid_scanout: read side of video memory. Generates raster timing, fetches
// one bitmap byte every 8 pixel clocks and shifts it out MSB-first as a
// 1-bit pixel stream with hsync/vsync/de. Never writes video memory.
//
// Everything runs on the falling edge of clk, like the CPU. rst is
// asynchronous and active-high.
//
// Ports:
//   clk         pixel clock (negedge active)
//   rst         asynchronous active-high reset
//   blank       forces pix=0 while high; timing keeps running
//   rd_addr     video read address (holds between fetches)
//   rd_en       high for one cycle per fetch
//   rd_data     read data, expected one clk after rd_addr/rd_en
//   pix         pixel value
//   de          active-area indicator
//   hsync/vsync sync outputs, active-low when SYNC_NEG=1
//   frame_start one-cycle pulse coinciding with pixel (0,0) on the outputs
//
// Read port contract: there is no valid/ready handshake and no stall. A fetch
// presents rd_en=1 with rd_addr for exactly one cycle, and the byte must be on
// rd_data when the next active clock edge samples it.
module vid_scanout #(
  parameter logic [14:0] BASE_ADDR = 15'h0000,
  parameter int          H_ACTIVE  = 256,
  parameter int          H_FP      = 16,
  parameter int          H_SYNC    = 32,
  parameter int          H_BP      = 16,
  parameter int          V_ACTIVE  = 192,
  parameter int          V_FP      = 4,
  parameter int          V_SYNC    = 4,
  parameter int          V_BP      = 12,
  parameter bit          SYNC_NEG  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        blank,
  output logic [14:0] rd_addr,
  output logic        rd_en,
  input  logic [7:0]  rd_data,
  output logic        pix,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BPL     = H_ACTIVE / 8;

  localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_PRE       = HW'(H_TOTAL - 2);
  localparam logic [HW-1:0] H_ACT       = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_FETCH_END = HW'(H_ACTIVE - 2);
  localparam logic [HW-1:0] HS_ON       = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_OFF      = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT       = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_ON       = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_OFF      = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [7:0]    prefetch;
  logic [7:0]    shifter;

  logic          h_wrap;
  logic [HW-1:0] h_next;
  logic [VW-1:0] v_next;
  logic [VW-1:0] line_after;

  logic          fetch_go;
  logic          fetch_ok;
  logic [VW-1:0] fetch_line;
  logic [HW-1:0] fetch_byte;
  logic [14:0]   fetch_addr;

  logic          active;
  logic          load;
  logic [7:0]    shift_d;
  logic          hs_act;
  logic          vs_act;

  assign h_wrap     = (h == H_LAST);
  assign line_after = (v == V_LAST) ? '0 : v + 1'b1;
  assign h_next     = h_wrap ? '0 : h + 1'b1;
  assign v_next     = h_wrap ? line_after : v;

  // Byte k of a line is requested two clocks before its first pixel. Byte 0
  // therefore belongs to the tail of the previous line, and targets the line
  // that follows (wrapping back to line 0 at the bottom of the frame).
  always_comb begin
    fetch_go   = 1'b0;
    fetch_line = v;
    fetch_byte = '0;
    if (h == H_PRE) begin
      fetch_go   = 1'b1;
      fetch_line = line_after;
    end else if ((h[2:0] == 3'd6) && (h < H_FETCH_END)) begin
      fetch_go   = 1'b1;
      fetch_byte = (h + HW'(2)) >> 3;
    end
  end

  assign fetch_ok   = fetch_go && (fetch_line < V_ACT);
  // 15-bit arithmetic: the address wraps modulo 2^15.
  assign fetch_addr = BASE_ADDR + 15'(fetch_line) * 15'(BPL) + 15'(fetch_byte);

  assign active  = (h < H_ACT) && (v < V_ACT);
  assign load    = active && (h[2:0] == 3'd0);
  // pix takes the bit the shifter is about to hold, so a freshly loaded
  // byte's MSB goes out in the same cycle the load happens.
  assign shift_d = load ? prefetch : {shifter[6:0], 1'b0};
  assign hs_act  = (h >= HS_ON) && (h < HS_OFF);
  assign vs_act  = (v >= VS_ON) && (v < VS_OFF);

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      h           <= H_PRE;
      v           <= V_LAST;
      rd_en       <= 1'b0;
      rd_addr     <= BASE_ADDR;
      prefetch    <= '0;
      shifter     <= '0;
      pix         <= 1'b0;
      de          <= 1'b0;
      hsync       <= SYNC_NEG;
      vsync       <= SYNC_NEG;
      frame_start <= 1'b0;
    end else begin
      h     <= h_next;
      v     <= v_next;
      rd_en <= fetch_ok;
      if (fetch_ok) begin
        rd_addr <= fetch_addr;
      end
      // rd_en is high exactly in the cycle whose closing edge sees the data.
      if (rd_en) begin
        prefetch <= rd_data;
      end
      shifter     <= shift_d;
      de          <= active;
      pix         <= active & shift_d[7] & ~blank;
      hsync       <= hs_act ^ SYNC_NEG;
      vsync       <= vs_act ^ SYNC_NEG;
      frame_start <= (h == '0) && (v == '0);
    end
  end

endmodule

// File: tb/tb_vid_scanout.sv
module tb_vid_scanout;

  localparam int HT      = 320;
  localparam int VT      = 212;
  localparam int HA      = 256;
  localparam int VA      = 192;
  localparam int BPL     = HA / 8;
  localparam int F       = HT * VT;
  localparam int HS_ON   = HA + 16;
  localparam int HS_OFF  = HS_ON + 32;
  localparam int VS_ON   = VA + 4;
  localparam int VS_OFF  = VS_ON + 4;
  localparam int P0      = (VT - 1) * HT + (HT - 2);
  localparam int NCYC    = 67860;
  localparam int RST_N_B = 16129;
  localparam int W       = 21;
  localparam logic [14:0] BASE_A = 15'h0000;
  localparam logic [14:0] BASE_B = 15'h7FF0;
  localparam logic [W-1:0] RESET_A = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, BASE_A};
  localparam logic [W-1:0] RESET_B = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, BASE_B};

  // clock / reset
  logic clk = 1'b1;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, blank;
  logic [7:0]  rd_data_a, rd_data_b;
  logic [14:0] rd_addr_a, rd_addr_b;
  logic        rd_en_a, rd_en_b;
  logic        pix_a, de_a, hsync_a, vsync_a, fs_a;
  logic        pix_b, de_b, hsync_b, vsync_b, fs_b;
  logic [W-1:0] obs_a, obs_b;

  logic [7:0] mem [32768];

  vid_scanout dut_a (
    .clk(clk), .rst(rst_a), .blank(blank),
    .rd_addr(rd_addr_a), .rd_en(rd_en_a), .rd_data(rd_data_a),
    .pix(pix_a), .de(de_a), .hsync(hsync_a), .vsync(vsync_a),
    .frame_start(fs_a)
  );

  vid_scanout #(.BASE_ADDR(BASE_B)) dut_b (
    .clk(clk), .rst(rst_b), .blank(blank),
    .rd_addr(rd_addr_b), .rd_en(rd_en_b), .rd_data(rd_data_b),
    .pix(pix_b), .de(de_b), .hsync(hsync_b), .vsync(vsync_b),
    .frame_start(fs_b)
  );

  assign obs_a = {pix_a, de_a, hsync_a, vsync_a, fs_a, rd_en_a, rd_addr_a};
  assign obs_b = {pix_b, de_b, hsync_b, vsync_b, fs_b, rd_en_b, rd_addr_b};

  // video memory: synchronous read, answers every cycle
  always @(posedge clk) begin
    if (rd_en_a) rd_data_a <= mem[rd_addr_a];
    if (rd_en_b) rd_data_b <= mem[rd_addr_b];
  end

  // scoreboard
  logic [W-1:0] exp_q_a[$];
  logic [W-1:0] exp_q_b[$];
  int checks   = 0;
  int failures = 0;
  bit mon_on   = 1'b0;

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outputs seen after edge n (n>=1) since reset release,
  // derived from raster position arithmetic.
  function automatic logic [W-1:0] model_out(input int n, input logic [14:0] base,
                                             input logic blank_s, input logic [14:0] last_addr,
                                             output logic [14:0] new_last);
    int pos, x, y, k, line;
    logic fetch, dev, pb, en;
    logic [14:0] a;
    logic [7:0] byte_v;
    pos = (P0 + n - 1) % F;
    x = pos % HT;
    y = pos / HT;
    dev = (x < HA) && (y < VA);
    a = 15'((int'(base) + y * BPL + x / 8) % 32768);
    byte_v = mem[a];
    pb = byte_v[7 - (x % 8)];
    fetch = 1'b0;
    k = 0;
    line = y;
    if (x == HT - 2) begin
      fetch = 1'b1;
      line = (y + 1) % VT;
    end else if ((x % 8 == 6) && (x + 2 < HA)) begin
      fetch = 1'b1;
      k = (x + 2) / 8;
    end
    new_last = last_addr;
    en = 1'b0;
    if (fetch && line < VA) begin
      en = 1'b1;
      new_last = 15'((int'(base) + line * BPL + k) % 32768);
    end
    return {dev && !blank_s && pb, dev, !(x >= HS_ON && x < HS_OFF),
            !(y >= VS_ON && y < VS_OFF), (x == 0 && y == 0), en, new_last};
  endfunction

  // monitor
  int s = 0;
  int pix_cnt = 0;
  logic [15:0] pix16 = '0;
  logic [14:0] max_addr = '0;
  bit seen_en_a = 1'b0;
  bit de_prev = 1'b0, hs_prev = 1'b1, vs_prev = 1'b1;
  bit hs_done = 1'b0, vs_done = 1'b0, hs_started = 1'b0, vs_started = 1'b0, de_seen = 1'b0;
  int de_rise_s = 0, hs_fall_s = 0, vs_fall_s = 0, fs_first_s = 0, fs_last_s = 0;
  int fs_count = 0;
  int en_cnt_b = 0;

  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (mon_on) begin
        s++;
        if (exp_q_a.size() == 0) begin
          checks++; failures++;
          $display("FAIL out_a: no expected entry at %0t", $time);
        end else begin
          e = exp_q_a.pop_front();
          check_val("out_a", 32'(obs_a), 32'(e));
        end
        if (exp_q_b.size() == 0) begin
          checks++; failures++;
          $display("FAIL out_b: no expected entry at %0t", $time);
        end else begin
          e = exp_q_b.pop_front();
          check_val("out_b", 32'(obs_b), 32'(e));
        end

        if (de_a && pix_cnt < 16) begin
          pix16 = {pix16[14:0], pix_a};
          pix_cnt++;
          if (pix_cnt == 16) check_val("first16_pix", 32'(pix16), 32'h0001);
        end
        if (rd_en_a && !seen_en_a) begin
          seen_en_a = 1'b1;
          check_val("first_rd_addr", 32'(rd_addr_a), 32'h0000);
        end
        if (rd_en_a && rd_addr_a > max_addr) max_addr = rd_addr_a;

        if (de_a && !de_prev && !de_seen) begin
          de_seen = 1'b1;
          de_rise_s = s;
        end
        if (de_seen && !hsync_a && hs_prev && !hs_started) begin
          hs_started = 1'b1;
          hs_fall_s = s;
          check_val("hsync_start", 32'(s - de_rise_s), 32'd272);
        end
        if (hs_started && hsync_a && !hs_prev && !hs_done) begin
          hs_done = 1'b1;
          check_val("hsync_width", 32'(s - hs_fall_s), 32'd32);
        end
        if (fs_count > 0 && !vsync_a && vs_prev && !vs_started) begin
          vs_started = 1'b1;
          vs_fall_s = s;
          check_val("vsync_start", 32'(s - fs_first_s), 32'(196 * HT));
        end
        if (vs_started && vsync_a && !vs_prev && !vs_done) begin
          vs_done = 1'b1;
          check_val("vsync_width", 32'(s - vs_fall_s), 32'(4 * HT));
        end
        if (fs_a) begin
          if (fs_count == 0) fs_first_s = s;
          else check_val("frame_period", 32'(s - fs_last_s), 32'(F));
          fs_last_s = s;
          fs_count++;
        end
        de_prev = de_a;
        hs_prev = hsync_a;
        vs_prev = vsync_a;

        if (rd_en_b) begin
          if (en_cnt_b == 16) check_val("wrap_addr_b", 32'(rd_addr_b), 32'h0000);
          en_cnt_b++;
        end
      end
    end
  end

  // driver
  initial begin
    int n_a, n_b, rel_b_c, opos;
    bit b_rst_done;
    logic [14:0] last_a, last_b, nl;
    logic [W-1:0] ev;
    rst_a = 1'b1;
    rst_b = 1'b1;
    blank = 1'b0;
    for (int a = 0; a < 32768; a++) mem[a] = 8'($urandom);
    for (int a = 0; a < BPL; a++) begin
      mem[a]           = 8'(a);
      mem[BPL + a]     = 8'hAA;
      mem[2 * BPL + a] = 8'h55;
    end
    mem[191 * BPL + 31] = 8'h01;
    n_a = 0; n_b = 0; rel_b_c = -1; b_rst_done = 1'b0;
    last_a = BASE_A; last_b = BASE_B;

    for (int c = 0; c < NCYC && failures < 100; c++) begin
      @(posedge clk);
      if (c == 2) begin
        rst_a = 1'b0;
        rst_b = 1'b0;
      end
      if (c == rel_b_c) rst_b = 1'b0;

      blank = ($urandom_range(0, 63) == 0);
      opos = (P0 + n_a) % F;
      if (!rst_a && opos >= 10 * HT + 100 && opos < 10 * HT + 140) blank = 1'b1;

      if (rst_a) begin
        exp_q_a.push_back(RESET_A);
      end else begin
        n_a++;
        ev = model_out(n_a, BASE_A, blank, last_a, nl);
        last_a = nl;
        exp_q_a.push_back(ev);
      end
      if (rst_b) begin
        exp_q_b.push_back(RESET_B);
      end else begin
        n_b++;
        ev = model_out(n_b, BASE_B, blank, last_b, nl);
        last_b = nl;
        exp_q_b.push_back(ev);
      end
      mon_on = 1'b1;

      // mid-frame reset of dut_b while its rd_en pulse is high (line 50)
      if (!rst_b && !b_rst_done && n_b == RST_N_B) begin
        b_rst_done = 1'b1;
        @(negedge clk);
        #3;
        check_val("rd_en_b_before_rst", 32'(rd_en_b), 32'd1);
        rst_b = 1'b1;
        #1;
        check_val("async_reset_b", 32'(obs_b), 32'(RESET_B));
        n_b = 0;
        last_b = BASE_B;
        rel_b_c = c + 4;
      end
    end

    @(negedge clk);
    #3;
    check_val("queue_drain", 32'(exp_q_a.size() + exp_q_b.size()), 32'd0);
    check_val("last_fetch_addr", 32'(max_addr), 32'h17FF);
    check_val("frame_count", 32'(fs_count), 32'd2);
    check_val("sync_measured", {30'd0, hs_done, vs_done}, 32'd3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
